// File: rtl/fpnew_lane_sequencer.sv
// rtl/fpnew_lane_sequencer.sv - time-multiplexes one scalar FP lane unit across all lanes of a wide op
// Issues one lane slice per handshake, reassembles returned lane results and OR-collapses their status.
module fpnew_lane_sequencer #(
   parameter int unsigned Width       = 32,
   parameter int unsigned FpWidth     = 16,
   parameter int unsigned NumOperands = 3,
   parameter int unsigned TagWidth    = 1,
   localparam int unsigned NUM_LANES  = Width / FpWidth,
   localparam int unsigned LIDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [NumOperands*Width-1:0]   operands_i,
   input  logic                           vectorial_op_i,
   input  logic [TagWidth-1:0]            tag_i,
   input  logic                           flush_i,
   output logic                           lane_valid_o,
   input  logic                           lane_ready_i,
   output logic [NumOperands*FpWidth-1:0] lane_operands_o,
   output logic [LIDX_W-1:0]              lane_idx_o,
   input  logic                           lane_res_valid_i,
   output logic                           lane_res_ready_o,
   input  logic [FpWidth-1:0]             lane_res_i,
   input  logic [4:0]                     lane_status_i,
   input  logic                           lane_ext_bit_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [Width-1:0]               result_o,
   output logic [4:0]                     status_o,
   output logic                           extension_bit_o,
   output logic [TagWidth-1:0]            tag_o,
   output logic                           busy_o
);
   localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE, DRAIN} state_e;

   state_e                       state_q;
   logic [NumOperands*Width-1:0] ops_q;
   logic                         vec_q;
   logic [CNT_W-1:0]             n_lanes_q;
   logic [CNT_W-1:0]             iss_cnt_q;
   logic [CNT_W-1:0]             ret_cnt_q;
   logic [CNT_W-1:0]             ret_inc;
   logic [CNT_W-1:0]             outstanding_nxt;
   logic [Width-1:0]             result_q;
   logic [4:0]                   status_q;
   logic                         ext_q;
   logic [TagWidth-1:0]          tag_q;
   logic                         issue_fire;
   logic                         ret_fire;

   assign in_ready_o       = (state_q == IDLE);
   assign busy_o           = (state_q != IDLE);
   assign out_valid_o      = (state_q == DONE);
   assign lane_valid_o     = (state_q == RUN) && (iss_cnt_q < n_lanes_q);
   assign lane_res_ready_o = (state_q == RUN) || (state_q == DRAIN);
   assign lane_idx_o       = iss_cnt_q[LIDX_W-1:0];
   assign issue_fire       = lane_valid_o && lane_ready_i;
   assign ret_fire         = lane_res_valid_i && lane_res_ready_o;
   assign ret_inc          = ret_cnt_q + CNT_W'(1);
   // Lane results still owed by the lane unit after this cycle's handshakes settle.
   assign outstanding_nxt  = iss_cnt_q + CNT_W'(issue_fire) - ret_cnt_q - CNT_W'(ret_fire);

   assign result_o         = result_q;
   assign status_o         = status_q;
   assign extension_bit_o  = ext_q;
   assign tag_o            = tag_q;

   always_comb begin
      lane_operands_o = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (iss_cnt_q == CNT_W'(l)) begin
            for (int i = 0; i < NumOperands; i++) begin
               lane_operands_o[i*FpWidth +: FpWidth] = ops_q[i*Width + l*FpWidth +: FpWidth];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ops_q     <= '0;
         vec_q     <= 1'b0;
         n_lanes_q <= '0;
         iss_cnt_q <= '0;
         ret_cnt_q <= '0;
         result_q  <= '0;
         status_q  <= '0;
         ext_q     <= 1'b0;
         tag_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  ops_q     <= operands_i;
                  vec_q     <= vectorial_op_i;
                  n_lanes_q <= vectorial_op_i ? CNT_W'(NUM_LANES) : CNT_W'(1);
                  tag_q     <= tag_i;
                  status_q  <= '0;
                  iss_cnt_q <= '0;
                  ret_cnt_q <= '0;
                  state_q   <= RUN;
               end
            end
            RUN: begin
               if (issue_fire) iss_cnt_q <= iss_cnt_q + CNT_W'(1);
               if (ret_fire) begin
                  ret_cnt_q <= ret_inc;
                  status_q  <= status_q | lane_status_i;
                  if (ret_cnt_q == '0) ext_q <= lane_ext_bit_i;
                  // A scalar result is NaN-boxed / sign-extended with lane 0's extension bit.
                  for (int l = 0; l < NUM_LANES; l++) begin
                     if (ret_cnt_q == CNT_W'(l))
                        result_q[l*FpWidth +: FpWidth] <= lane_res_i;
                     else if (!vec_q && ret_cnt_q == '0)
                        result_q[l*FpWidth +: FpWidth] <= {FpWidth{lane_ext_bit_i}};
                  end
               end
               if (flush_i)
                  state_q <= (outstanding_nxt == '0) ? IDLE : DRAIN;
               else if (ret_fire && ret_inc == n_lanes_q)
                  state_q <= DONE;
            end
            DONE: begin
               if (flush_i || out_ready_i) state_q <= IDLE;
            end
            DRAIN: begin
               if (ret_fire) begin
                  ret_cnt_q <= ret_inc;
                  if (ret_inc == iss_cnt_q) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// tb/tb_fpnew_lane_sequencer.sv - directed table-driven bench for fpnew_lane_sequencer
// Lane unit model echoes the operand-0 slice after a configurable latency.
module tb_fpnew_lane_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [95:0] operands_i;
   logic        vectorial_op_i;
   logic [0:0]  tag_i;
   logic        flush_i;
   logic        lane_valid_o;
   logic        lane_ready_i;
   logic [47:0] lane_operands_o;
   logic [0:0]  lane_idx_o;
   logic        lane_res_valid_i;
   logic        lane_res_ready_o;
   logic [15:0] lane_res_i;
   logic [4:0]  lane_status_i;
   logic        lane_ext_bit_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic [4:0]  status_o;
   logic        extension_bit_o;
   logic [0:0]  tag_o;
   logic        busy_o;

   fpnew_lane_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .operands_i(operands_i), .vectorial_op_i(vectorial_op_i), .tag_i(tag_i), .flush_i(flush_i),
      .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_operands_o(lane_operands_o),
      .lane_idx_o(lane_idx_o), .lane_res_valid_i(lane_res_valid_i), .lane_res_ready_o(lane_res_ready_o),
      .lane_res_i(lane_res_i), .lane_status_i(lane_status_i), .lane_ext_bit_i(lane_ext_bit_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o), .status_o(status_o),
      .extension_bit_o(extension_bit_o), .tag_o(tag_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0] data;
      logic [4:0]  st;
      logic        ext;
      int          due;
   } lres_t;

   typedef struct {
      logic        vec;
      logic [31:0] op0;
      logic        tag;
      int          lat;
      logic [4:0]  st0, st1;
      logic        ext0, ext1;
      logic [31:0] exp_res;
      logic [4:0]  exp_st;
      int          exp_iss;
   } vec_t;

   lres_t      q[$];
   int         lat = 1;
   logic [4:0] m_st[2];
   logic       m_ext[2];
   int         n_iss = 0;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   vec_t       tv[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [47:0] exp_slice(input logic [31:0] o0, input int k);
      logic [31:0] o1, o2;
      o1 = ~o0;
      o2 = o0 ^ 32'h5A5A_5A5A;
      return {o2[16*k +: 16], o1[16*k +: 16], o0[16*k +: 16]};
   endfunction

   task automatic drive_lane();
      if (q.size() > 0 && q[0].due <= cyc) begin
         lane_res_valid_i = 1'b1;
         lane_res_i       = q[0].data;
         lane_status_i    = q[0].st;
         lane_ext_bit_i   = q[0].ext;
      end else begin
         lane_res_valid_i = 1'b0;
         lane_res_i       = '0;
         lane_status_i    = '0;
         lane_ext_bit_i   = 1'b0;
      end
   endtask

   task automatic tick();
      bit          iss, pop;
      logic [15:0] d;
      iss = lane_valid_o && lane_ready_i;
      pop = lane_res_valid_i && lane_res_ready_o;
      d   = lane_operands_o[15:0];
      @(posedge clk_i);
      #1;
      cyc++;
      if (rst_i) begin
         q.delete();
      end else begin
         if (pop && q.size() > 0) void'(q.pop_front());
         if (iss) begin
            q.push_back('{d, m_st[n_iss % 2], m_ext[n_iss % 2], cyc + lat - 1});
            n_iss++;
         end
      end
      drive_lane();
   endtask

   task automatic drive_op(input logic vec, input logic [31:0] o0, input logic tg);
      operands_i     = {o0 ^ 32'h5A5A_5A5A, ~o0, o0};
      vectorial_op_i = vec;
      tag_i          = tg;
      in_valid_i     = 1'b1;
   endtask

   task automatic run_op(input vec_t v);
      int k, r, nexp;
      bit last;
      lat = v.lat; m_st[0] = v.st0; m_st[1] = v.st1; m_ext[0] = v.ext0; m_ext[1] = v.ext1; n_iss = 0;
      chk("in_ready_idle", 64'(in_ready_o), 64'd1);
      drive_op(v.vec, v.op0, v.tag);
      tick();
      in_valid_i = 1'b0;
      nexp = v.vec ? 2 : 1;
      k = 0; r = 0; last = 0;
      for (int b = 0; b < 40 && !last; b++) begin
         chk("early_out_valid", 64'(out_valid_o), 64'd0);
         if (lane_valid_o && lane_ready_i) begin
            chk("lane_idx", 64'(lane_idx_o), 64'(k));
            if (k < 2) chk("lane_operands", 64'(lane_operands_o), 64'(exp_slice(v.op0, k)));
            k++;
         end
         if (lane_res_valid_i && lane_res_ready_o) begin
            r++;
            last = (r == nexp);
         end
         tick();
      end
      if (!last) chk("return_timeout", 64'd0, 64'd1);
      chk("out_valid_after_last_ret", 64'(out_valid_o), 64'd1);
      chk("result", 64'(result_o), 64'(v.exp_res));
      chk("status", 64'(status_o), 64'(v.exp_st));
      chk("ext_bit", 64'(extension_bit_o), 64'(v.ext0));
      chk("tag", 64'(tag_o), 64'(v.tag));
      chk("issue_count", 64'(k), 64'(v.exp_iss));
      chk("in_ready_done", 64'(in_ready_o), 64'd0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("idle_after_out", 64'(in_ready_o), 64'd1);
      chk("busy_after_out", 64'(busy_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{1'b1, 32'hABCD_1234, 1'b0, 2, 5'b00000, 5'b00000, 1'b0, 1'b1, 32'hABCD_1234, 5'b00000, 2};
      tv[1] = '{1'b0, 32'h5555_1234, 1'b0, 1, 5'b00010, 5'b00000, 1'b1, 1'b0, 32'hFFFF_1234, 5'b00010, 1};
      tv[2] = '{1'b1, 32'h1111_2222, 1'b1, 1, 5'b00001, 5'b10000, 1'b1, 1'b0, 32'h1111_2222, 5'b10001, 2};
      tv[3] = '{1'b0, 32'hFFFF_8001, 1'b1, 3, 5'b00000, 5'b00000, 1'b0, 1'b1, 32'h0000_8001, 5'b00000, 1};
      tv[4] = '{1'b1, 32'h0F0F_F0F0, 1'b0, 1, 5'b00100, 5'b00100, 1'b0, 1'b1, 32'h0F0F_F0F0, 5'b00100, 2};

      rst_i = 1'b1; in_valid_i = 1'b0; operands_i = '0; vectorial_op_i = 1'b0; tag_i = '0;
      flush_i = 1'b0; lane_ready_i = 1'b1; out_ready_i = 1'b0;
      m_st[0] = '0; m_st[1] = '0; m_ext[0] = 1'b0; m_ext[1] = 1'b0;
      drive_lane();
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready_o), 64'd1);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("rst_lane_valid", 64'(lane_valid_o), 64'd0);
      chk("rst_lane_res_ready", 64'(lane_res_ready_o), 64'd0);
      chk("rst_result", 64'(result_o), 64'd0);
      chk("rst_status", 64'(status_o), 64'd0);
      chk("rst_tag", 64'(tag_o), 64'd0);
      rst_i = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_op(tv[i]);

      // reset asserted for two cycles in the middle of a vector op
      lat = 2; n_iss = 0;
      drive_op(1'b1, 32'h1357_9BDF, 1'b1);
      tick();
      in_valid_i = 1'b0;
      tick();
      chk("midrst_busy_before", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
      chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_lane_valid", 64'(lane_valid_o), 64'd0);

      // issue stall and output backpressure hold everything stable
      lat = 1; n_iss = 0; lane_ready_i = 1'b0;
      drive_op(1'b1, 32'hCAFE_BEEF, 1'b1);
      tick();
      in_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("stall_lane_valid", 64'(lane_valid_o), 64'd1);
         chk("stall_lane_idx", 64'(lane_idx_o), 64'd0);
         chk("stall_lane_operands", 64'(lane_operands_o), 64'(exp_slice(32'hCAFE_BEEF, 0)));
         tick();
      end
      lane_ready_i = 1'b1;
      for (int b = 0; b < 20 && !out_valid_o; b++) tick();
      for (int c = 0; c < 4; c++) begin
         chk("bp_out_valid", 64'(out_valid_o), 64'd1);
         chk("bp_result", 64'(result_o), 64'h0000_0000_CAFE_BEEF);
         chk("bp_tag", 64'(tag_o), 64'd1);
         tick();
      end
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("bp_idle", 64'(in_ready_o), 64'd1);

      // flush with one lane result outstanding drains before going idle
      lat = 3; n_iss = 0;
      drive_op(1'b1, 32'h2468_ACE0, 1'b0);
      tick();
      in_valid_i = 1'b0;
      tick();
      lane_ready_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("drain_in_ready", 64'(in_ready_o), 64'd0);
      chk("drain_busy", 64'(busy_o), 64'd1);
      chk("drain_lane_valid", 64'(lane_valid_o), 64'd0);
      chk("drain_res_ready", 64'(lane_res_ready_o), 64'd1);
      begin
         int b;
         for (b = 0; b < 10 && busy_o; b++) begin
            chk("drain_no_out_valid", 64'(out_valid_o), 64'd0);
            chk("drain_no_in_ready", 64'(in_ready_o), 64'd0);
            tick();
         end
         chk("drain_cycles", 64'(b), 64'd2);
      end
      chk("drain_done_idle", 64'(in_ready_o), 64'd1);
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
      lane_ready_i = 1'b1;

      // flush with nothing outstanding returns straight to idle
      lane_ready_i = 1'b0;
      drive_op(1'b1, 32'h0000_FFFF, 1'b0);
      tick();
      in_valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush0_in_ready", 64'(in_ready_o), 64'd1);
      chk("flush0_busy", 64'(busy_o), 64'd0);
      chk("flush0_out_valid", 64'(out_valid_o), 64'd0);
      lane_ready_i = 1'b1;

      run_op(tv[2]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
